// File: rtl/taint_mon_pkg.sv
// Shared types for the taint event monitor: FSM states, event indices, cause codes
// and the per-channel decoded-event bundle.
package taint_mon_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int NumEvents   = 6;
  localparam int EvStop      = 0;
  localparam int EvTrap      = 1;
  localparam int EvBusTaint  = 2;
  localparam int EvPcTaint   = 3;
  localparam int EvPcX       = 4;
  localparam int EvAddrTaint = 5;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseSimlen  = 3'd1,
    CauseStop    = 3'd2,
    CauseTrap    = 3'd3,
    CausePcTaint = 3'd4,
    CausePcX     = 3'd5
  } cause_e;

  typedef struct packed {
    logic stop;
    logic trap;
    logic bus_taint;
    logic addr_taint;
    logic wdata_taint;
  } ch_ev_t;

endpackage

// File: rtl/taint_mon_channel.sv
// Combinational event decode for one monitored memory port; zero latency,
// no flow control (pure observer).
module taint_mon_channel
  import taint_mon_pkg::*;
#(
  parameter int AddrWidth = 15,
  parameter int DataWidth = 32,
  parameter int StopAddr  = 0,
  parameter int TrapAddr  = 8
) (
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] addr_t0_i,
  input  logic [DataWidth-1:0] wdata_t0_i,
  input  logic [DataWidth-1:0] rdata_t0_i,
  output ch_ev_t               ev_o
);

  logic wr;

  assign wr               = req_i & we_i;
  assign ev_o.stop        = wr && (addr_i == AddrWidth'(StopAddr));
  assign ev_o.trap        = wr && (addr_i == AddrWidth'(TrapAddr));
  assign ev_o.bus_taint   = |rdata_t0_i;
  assign ev_o.addr_taint  = |addr_t0_i;
  assign ev_o.wdata_taint = |wdata_t0_i;

endmodule

// File: rtl/taint_event_monitor.sv
// Run-control and sticky taint-event recorder; all outputs registered (one edge after
// the observed cycle). Pure observer: never stalls the monitored ports.
module taint_event_monitor
  import taint_mon_pkg::*;
#(
  parameter int NumChannels  = 2,
  parameter int AddrWidth    = 15,
  parameter int DataWidth    = 32,
  parameter int CntWidth     = 32,
  parameter int DrainCycles  = 50,
  parameter int WarmupCycles = 10,
  parameter int StopAddr     = 0,
  parameter int TrapAddr     = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enable_i,
  input  logic [CntWidth-1:0]                   simlen_i,
  input  logic                                  stop_on_trap_i,
  input  logic [NumChannels-1:0]                ch_req_i,
  input  logic [NumChannels-1:0]                ch_we_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] ch_addr_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] ch_addr_t0_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] ch_wdata_t0_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] ch_rdata_t0_i,
  input  logic [31:0]                           pc_t0_i,
  input  logic                                  pc_x_i,
  output logic                                  done_o,
  output logic [2:0]                            cause_o,
  output logic [NumEvents-1:0]                  event_flags_o,
  output logic [NumEvents-1:0][CntWidth-1:0]    event_cycle_o,
  output logic [CntWidth-1:0]                   cycle_o,
  output logic                                  dest_tainted_o
);

  state_e                             state_q, state_d;
  cause_e                             cause_q, cause_d, trig_cause;
  logic [CntWidth-1:0]                cycle_q, cycle_d;
  logic [CntWidth-1:0]                drain_q, drain_d;
  logic [NumEvents-1:0]               flags_q, flags_d;
  logic [NumEvents-1:0][CntWidth-1:0] stamp_q, stamp_d;
  logic                               dest_q, dest_d;

  ch_ev_t [NumChannels-1:0] ch_ev;
  logic [NumEvents-1:0]     ev;
  logic                     stop_wtaint;
  logic                     active;
  logic                     simlen_hit;

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    taint_mon_channel #(
      .AddrWidth(AddrWidth),
      .DataWidth(DataWidth),
      .StopAddr (StopAddr),
      .TrapAddr (TrapAddr)
    ) u_ch (
      .req_i     (ch_req_i[g]),
      .we_i      (ch_we_i[g]),
      .addr_i    (ch_addr_i[g]),
      .addr_t0_i (ch_addr_t0_i[g]),
      .wdata_t0_i(ch_wdata_t0_i[g]),
      .rdata_t0_i(ch_rdata_t0_i[g]),
      .ev_o      (ch_ev[g])
    );
  end

  // Descending scan so the lowest-index stopping channel supplies the write taint.
  always_comb begin
    ev          = '0;
    stop_wtaint = 1'b0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      ev[EvStop]      = ev[EvStop]      | ch_ev[i].stop;
      ev[EvTrap]      = ev[EvTrap]      | ch_ev[i].trap;
      ev[EvBusTaint]  = ev[EvBusTaint]  | ch_ev[i].bus_taint;
      ev[EvAddrTaint] = ev[EvAddrTaint] | ch_ev[i].addr_taint;
      if (ch_ev[i].stop) begin
        stop_wtaint = ch_ev[i].wdata_taint;
      end
    end
    ev[EvPcTaint] = |pc_t0_i;
    ev[EvPcX]     = pc_x_i && (cycle_q >= CntWidth'(WarmupCycles));
  end

  always_comb begin
    trig_cause = CauseNone;
    if (ev[EvStop]) begin
      trig_cause = CauseStop;
    end else if (ev[EvTrap] && stop_on_trap_i) begin
      trig_cause = CauseTrap;
    end else if (ev[EvPcTaint]) begin
      trig_cause = CausePcTaint;
    end else if (ev[EvPcX]) begin
      trig_cause = CausePcX;
    end
  end

  assign active     = (state_q == StRun) || (state_q == StDrain);
  assign simlen_hit = (simlen_i != '0) && (cycle_q == simlen_i - CntWidth'(1));

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    drain_d = drain_q;
    cause_d = cause_q;
    flags_d = flags_q;
    stamp_d = stamp_q;
    dest_d  = dest_q;

    if (active) begin
      if (cycle_q != '1) begin
        cycle_d = cycle_q + CntWidth'(1);
      end
      for (int e = 0; e < NumEvents; e++) begin
        if (ev[e] && !flags_q[e]) begin
          flags_d[e] = 1'b1;
          stamp_d[e] = cycle_q;
        end
      end
      if (ev[EvStop] && !flags_q[EvStop]) begin
        dest_d = stop_wtaint;
      end
    end

    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // The cycle limit wins over any trigger seen in the same cycle.
        if (simlen_hit) begin
          state_d = StDone;
          cause_d = CauseSimlen;
        end else if (trig_cause != CauseNone) begin
          state_d = StDrain;
          drain_d = CntWidth'(DrainCycles);
          cause_d = trig_cause;
        end
      end
      StDrain: begin
        if (simlen_hit || (drain_q == '0)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - CntWidth'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cycle_q <= '0;
      drain_q <= '0;
      cause_q <= CauseNone;
      flags_q <= '0;
      stamp_q <= '0;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      flags_q <= flags_d;
      stamp_q <= stamp_d;
      dest_q  <= dest_d;
    end
  end

  assign done_o         = (state_q == StDone);
  assign cause_o        = cause_q;
  assign event_flags_o  = flags_q;
  assign event_cycle_o  = stamp_q;
  assign cycle_o        = cycle_q;
  assign dest_tainted_o = dest_q;

endmodule

// File: tb/tb_taint_event_monitor.sv
// Randomized and scenario-driven bench for taint_event_monitor against a
// timeline-based reference model.
module tb_taint_event_monitor;

  localparam int NC     = 2;
  localparam int AW     = 15;
  localparam int DW     = 32;
  localparam int CW     = 32;
  localparam int DRAIN  = 50;
  localparam int WARMUP = 10;
  localparam int STOP_A = 0;
  localparam int TRAP_A = 8;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   enable_i;
  logic [CW-1:0]          simlen_i;
  logic                   stop_on_trap_i;
  logic [NC-1:0]          ch_req_i;
  logic [NC-1:0]          ch_we_i;
  logic [NC-1:0][AW-1:0]  ch_addr_i;
  logic [NC-1:0][AW-1:0]  ch_addr_t0_i;
  logic [NC-1:0][DW-1:0]  ch_wdata_t0_i;
  logic [NC-1:0][DW-1:0]  ch_rdata_t0_i;
  logic [31:0]            pc_t0_i;
  logic                   pc_x_i;
  logic                   done_o;
  logic [2:0]             cause_o;
  logic [5:0]             event_flags_o;
  logic [5:0][CW-1:0]     event_cycle_o;
  logic [CW-1:0]          cycle_o;
  logic                   dest_tainted_o;

  always #5 clk_i = ~clk_i;

  taint_event_monitor #(
    .NumChannels (NC),
    .AddrWidth   (AW),
    .DataWidth   (DW),
    .CntWidth    (CW),
    .DrainCycles (DRAIN),
    .WarmupCycles(WARMUP),
    .StopAddr    (STOP_A),
    .TrapAddr    (TRAP_A)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .simlen_i      (simlen_i),
    .stop_on_trap_i(stop_on_trap_i),
    .ch_req_i      (ch_req_i),
    .ch_we_i       (ch_we_i),
    .ch_addr_i     (ch_addr_i),
    .ch_addr_t0_i  (ch_addr_t0_i),
    .ch_wdata_t0_i (ch_wdata_t0_i),
    .ch_rdata_t0_i (ch_rdata_t0_i),
    .pc_t0_i       (pc_t0_i),
    .pc_x_i        (pc_x_i),
    .done_o        (done_o),
    .cause_o       (cause_o),
    .event_flags_o (event_flags_o),
    .event_cycle_o (event_cycle_o),
    .cycle_o       (cycle_o),
    .dest_tainted_o(dest_tainted_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: run timeline expressed as cycle numbers.
  bit       m_started;
  bit       m_done;
  int       m_cycle;
  int       m_trig;      // cycle of the trigger, -1 while none
  int       m_cause;
  bit [5:0] m_flags;
  int       m_stamp[6];
  bit       m_dest;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_done    = 0;
    m_cycle   = 0;
    m_trig    = -1;
    m_cause   = 0;
    m_flags   = '0;
    m_dest    = 0;
    for (int e = 0; e < 6; e++) m_stamp[e] = 0;
  endtask

  task automatic model_step();
    bit [5:0] ev;
    int       sel_ch;
    int       sl;
    bit       last;
    if (!m_started) begin
      if (enable_i) m_started = 1;
      return;
    end
    if (m_done) return;
    ev     = '0;
    sel_ch = 0;
    for (int ch = NC - 1; ch >= 0; ch--) begin
      if (ch_req_i[ch] && ch_we_i[ch] && ch_addr_i[ch] == AW'(STOP_A)) begin
        ev[0]  = 1;
        sel_ch = ch;
      end
      if (ch_req_i[ch] && ch_we_i[ch] && ch_addr_i[ch] == AW'(TRAP_A)) ev[1] = 1;
      if (ch_rdata_t0_i[ch] != '0) ev[2] = 1;
      if (ch_addr_t0_i[ch] != '0) ev[5] = 1;
    end
    ev[3] = (pc_t0_i != '0);
    ev[4] = pc_x_i && (m_cycle >= WARMUP);
    if (ev[0] && !m_flags[0]) m_dest = (ch_wdata_t0_i[sel_ch] != '0);
    for (int e = 0; e < 6; e++) begin
      if (ev[e] && !m_flags[e]) begin
        m_flags[e] = 1;
        m_stamp[e] = m_cycle;
      end
    end
    sl   = int'(simlen_i);
    last = (sl != 0) && (m_cycle == sl - 1);
    if (m_trig < 0) begin
      if (last) begin
        m_done = 1; m_cause = 1;
      end else if (ev[0]) begin
        m_trig = m_cycle; m_cause = 2;
      end else if (ev[1] && stop_on_trap_i) begin
        m_trig = m_cycle; m_cause = 3;
      end else if (ev[3]) begin
        m_trig = m_cycle; m_cause = 4;
      end else if (ev[4]) begin
        m_trig = m_cycle; m_cause = 5;
      end
    end else if (last || m_cycle == m_trig + DRAIN + 1) begin
      m_done = 1;
    end
    m_cycle++;
  endtask

  task automatic compare_all();
    check_eq("done", 64'(done_o), 64'(m_done));
    check_eq("cause", 64'(cause_o), 64'(m_cause));
    check_eq("flags", 64'(event_flags_o), 64'(m_flags));
    check_eq("cycle", 64'(cycle_o), 64'(m_cycle));
    check_eq("dest_tainted", 64'(dest_tainted_o), 64'(m_dest));
    for (int e = 0; e < 6; e++)
      check_eq($sformatf("event_cycle%0d", e), 64'(event_cycle_o[e]), 64'(m_stamp[e]));
  endtask

  task automatic clear_inputs();
    enable_i      = 1'b0;
    ch_req_i      = '0;
    ch_we_i       = '0;
    ch_addr_i     = '0;
    ch_addr_t0_i  = '0;
    ch_wdata_t0_i = '0;
    ch_rdata_t0_i = '0;
    pc_t0_i       = '0;
    pc_x_i        = 1'b0;
  endtask

  task automatic drive_random();
    int r;
    for (int ch = 0; ch < NC; ch++) begin
      ch_req_i[ch] = ($urandom_range(0, 1) == 1);
      ch_we_i[ch]  = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 59);
      ch_addr_i[ch]     = (r == 0) ? AW'(STOP_A) : (r <= 2) ? AW'(TRAP_A) : AW'($urandom);
      ch_addr_t0_i[ch]  = ($urandom_range(0, 79) == 0) ? AW'(32'd1 << $urandom_range(0, AW - 1)) : '0;
      ch_rdata_t0_i[ch] = ($urandom_range(0, 29) == 0) ? $urandom : '0;
      ch_wdata_t0_i[ch] = ($urandom_range(0, 1) == 1) ? $urandom : '0;
    end
    pc_t0_i = ($urandom_range(0, 199) == 0) ? $urandom : '0;
    pc_x_i  = ($urandom_range(0, 29) == 0);
  endtask

  task automatic drive(input int mode);
    int c;
    c = m_cycle;
    clear_inputs();
    enable_i = !m_started;
    if (!m_started) return;
    case (mode)
      0: if (c == 20) begin
        ch_req_i[1] = 1'b1; ch_we_i[1] = 1'b1;
        ch_addr_i[1] = AW'(STOP_A); ch_wdata_t0_i[1] = 32'h1;
      end
      1: pc_x_i = (c >= 5 && c <= 9) || (c == 12);
      2: ;
      3: begin
        if (c == 30 || c == 40) begin
          ch_req_i[0] = 1'b1; ch_we_i[0] = 1'b1;
          ch_addr_i[0] = (c == 30) ? AW'(TRAP_A) : AW'(STOP_A);
        end
      end
      4: if (c == 15) begin
        ch_req_i = '1; ch_we_i = '1;
        ch_addr_i[0] = AW'(STOP_A); ch_addr_i[1] = AW'(STOP_A);
        ch_wdata_t0_i[0] = 32'h0; ch_wdata_t0_i[1] = 32'hFF;
      end
      5: if (c == 10) pc_t0_i = 32'h4;
      default: begin
        drive_random();
        enable_i = ($urandom_range(0, 1) == 1);
      end
    endcase
  endtask

  task automatic tick_and_compare();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
    rst_i = 1'b0;
  endtask

  task automatic run_scenario(input int mode);
    int n;
    do_reset();
    simlen_i       = '0;
    stop_on_trap_i = 1'b0;
    if (mode == 2) simlen_i = CW'(100);
    if (mode >= 6) begin
      simlen_i       = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(5, 120)) : '0;
      stop_on_trap_i = ($urandom_range(0, 1) == 1);
      repeat (3) begin
        drive_random();
        enable_i = 1'b0;
        tick_and_compare();
      end
    end
    n = 0;
    while (!m_done && n < 400) begin
      drive(mode);
      tick_and_compare();
      n++;
      if (mode == 5 && m_trig >= 0 && m_cycle == m_trig + 26) begin
        #2 rst_i = 1'b1;
        #1;
        check_eq("rst_async_done", 64'(done_o), 64'(0));
        check_eq("rst_async_cause", 64'(cause_o), 64'(0));
        check_eq("rst_async_flags", 64'(event_flags_o), 64'(0));
        check_eq("rst_async_cycle", 64'(cycle_o), 64'(0));
        check_eq("rst_async_stamp3", 64'(event_cycle_o[3]), 64'(0));
        check_eq("rst_async_dest", 64'(dest_tainted_o), 64'(0));
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
        rst_i = 1'b0;
        repeat (3) begin
          drive_random();
          enable_i = 1'b0;
          tick_and_compare();
        end
        return;
      end
    end
    check_eq("run_reached_done", 64'(done_o), 64'(1));
    repeat (3) begin
      drive(6);
      tick_and_compare();
    end
    case (mode)
      0: begin
        check_eq("s0_cause", 64'(cause_o), 64'(2));
        check_eq("s0_stamp0", 64'(event_cycle_o[0]), 64'(20));
        check_eq("s0_dest", 64'(dest_tainted_o), 64'(1));
        check_eq("s0_flags", 64'(event_flags_o), 64'(6'b000001));
        check_eq("s0_cycle", 64'(cycle_o), 64'(20 + 52));
      end
      1: begin
        check_eq("s1_cause", 64'(cause_o), 64'(5));
        check_eq("s1_stamp4", 64'(event_cycle_o[4]), 64'(12));
        check_eq("s1_flags", 64'(event_flags_o), 64'(6'b010000));
        check_eq("s1_cycle", 64'(cycle_o), 64'(12 + 52));
      end
      2: begin
        check_eq("s2_cause", 64'(cause_o), 64'(1));
        check_eq("s2_flags", 64'(event_flags_o), 64'(0));
        check_eq("s2_cycle", 64'(cycle_o), 64'(100));
      end
      3: begin
        check_eq("s3_flags", 64'(event_flags_o), 64'(6'b000011));
        check_eq("s3_stamp1", 64'(event_cycle_o[1]), 64'(30));
        check_eq("s3_stamp0", 64'(event_cycle_o[0]), 64'(40));
        check_eq("s3_cause", 64'(cause_o), 64'(2));
        check_eq("s3_cycle", 64'(cycle_o), 64'(40 + 52));
      end
      4: begin
        check_eq("s4_dest", 64'(dest_tainted_o), 64'(0));
        check_eq("s4_cause", 64'(cause_o), 64'(2));
        check_eq("s4_stamp0", 64'(event_cycle_o[0]), 64'(15));
      end
      default: ;
    endcase
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    simlen_i       = '0;
    stop_on_trap_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    for (int mode = 0; mode < 14; mode++) run_scenario(mode);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
